// File: rtl/fsm_control_pkg.sv
// Shared transaction-layer definitions: one-hot state encodings and the
// FIFO threshold defaults applied at reset.
package fsm_control_pkg;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  localparam int NUM_FIFOS_DEF = 5;
  localparam int TH_WIDTH_DEF  = 3;
  localparam int TH_HI_RST_DEF = 6;
  localparam int TH_LO_RST_DEF = 1;

endpackage

// File: rtl/fsm_control_umbrales_reg.sv
// Threshold capture register: holds the almost-full/almost-empty thresholds,
// reloads them from the inputs whenever load is high, returns to defaults on reset.
module umbrales_reg #(
  parameter int TH_WIDTH  = 3,
  parameter int TH_HI_RST = 6,
  parameter int TH_LO_RST = 1
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                load,
  input  logic [TH_WIDTH-1:0] hi_in,
  input  logic [TH_WIDTH-1:0] lo_in,
  output logic [TH_WIDTH-1:0] hi,
  output logic [TH_WIDTH-1:0] lo
);

  // Capture thresholds while loading; otherwise hold the last captured pair.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hi <= TH_WIDTH'(TH_HI_RST);
      lo <= TH_WIDTH'(TH_LO_RST);
    end else if (load) begin
      hi <= hi_in;
      lo <= lo_in;
    end
  end

endmodule

// File: rtl/fsm_control.sv
// Main control FSM of the transaction layer: RESET -> INIT -> IDLE/ACTIVE,
// with a sticky ERROR state left only through reset.
module fsm_control
  import fsm_control_pkg::*;
#(
  parameter int NUM_FIFOS = NUM_FIFOS_DEF,
  parameter int TH_WIDTH  = TH_WIDTH_DEF,
  parameter int TH_HI_RST = TH_HI_RST_DEF,
  parameter int TH_LO_RST = TH_LO_RST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 init,
  input  logic [TH_WIDTH-1:0]  th_hi_in,
  input  logic [TH_WIDTH-1:0]  th_lo_in,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_error,
  output logic [TH_WIDTH-1:0]  th_hi,
  output logic [TH_WIDTH-1:0]  th_lo,
  output logic                 idle,
  output logic                 active,
  output logic                 error_out,
  output logic [NUM_FIFOS-1:0] error_src,
  output logic [4:0]           state
);

  state_t                 state_q, state_d;
  logic [NUM_FIFOS-1:0]   error_src_q, error_src_d;

  // State and error-source registers; reset returns to RESET with no recorded error.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_RESET;
      error_src_q <= '0;
    end else begin
      state_q     <= state_d;
      error_src_q <= error_src_d;
    end
  end

  // Next-state logic; errors beat init, init beats data-driven IDLE/ACTIVE moves.
  always_comb begin
    state_d     = state_q;
    error_src_d = error_src_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        // fifo_error is deliberately not looked at here: pulses during INIT are dropped.
        if (!init) begin
          if (th_lo_in >= th_hi_in) begin
            state_d     = ST_ERROR;
            error_src_d = '0;
          end else if (&fifo_empty) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_IDLE: begin
        if (|fifo_error) begin
          state_d     = ST_ERROR;
          error_src_d = fifo_error;
        end else if (init) begin
          state_d = ST_INIT;
        end else if (!(&fifo_empty)) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (|fifo_error) begin
          state_d     = ST_ERROR;
          error_src_d = fifo_error;
        end else if (init) begin
          state_d = ST_INIT;
        end else if (&fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      // Any corrupted, non-one-hot encoding recovers through RESET.
      default:  state_d = ST_RESET;
    endcase
  end

  umbrales_reg #(
    .TH_WIDTH  (TH_WIDTH),
    .TH_HI_RST (TH_HI_RST),
    .TH_LO_RST (TH_LO_RST)
  ) u_umbrales (
    .clk   (clk),
    .rst_l (rst_l),
    .load  (state_q == ST_INIT),
    .hi_in (th_hi_in),
    .lo_in (th_lo_in),
    .hi    (th_hi),
    .lo    (th_lo)
  );

  assign state     = state_q;
  assign idle      = (state_q == ST_IDLE);
  assign active    = (state_q == ST_ACTIVE);
  assign error_out = (state_q == ST_ERROR);
  assign error_src = error_src_q;

endmodule

// File: tb/tb_fsm_control.sv
// Directed bench for fsm_control: reset, init/threshold load, IDLE/ACTIVE
// moves, error capture and stickiness, bad config, async reset.
module tb_fsm_control;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       init;
  logic [2:0] th_hi_in, th_lo_in;
  logic [4:0] fifo_empty, fifo_error;
  logic [2:0] th_hi, th_lo;
  logic       idle, active, error_out;
  logic [4:0] error_src;
  logic [4:0] state;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] S_RESET  = 5'b00001;
  localparam logic [4:0] S_INIT   = 5'b00010;
  localparam logic [4:0] S_IDLE   = 5'b00100;
  localparam logic [4:0] S_ACTIVE = 5'b01000;
  localparam logic [4:0] S_ERROR  = 5'b10000;

  fsm_control dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .init       (init),
    .th_hi_in   (th_hi_in),
    .th_lo_in   (th_lo_in),
    .fifo_empty (fifo_empty),
    .fifo_error (fifo_error),
    .th_hi      (th_hi),
    .th_lo      (th_lo),
    .idle       (idle),
    .active     (active),
    .error_out  (error_out),
    .error_src  (error_src),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full set of Moore outputs for a given state.
  task automatic chk_state(input string tag, input logic [4:0] exp);
    chk({tag, ".state"}, state, exp);
    chk({tag, ".idle"}, idle, exp == S_IDLE);
    chk({tag, ".active"}, active, exp == S_ACTIVE);
    chk({tag, ".error_out"}, error_out, exp == S_ERROR);
  endtask

  initial begin
    rst_l      = 1'b0;
    init       = 1'b0;
    th_hi_in   = 3'd6;
    th_lo_in   = 3'd1;
    fifo_empty = 5'b11111;
    fifo_error = 5'b00000;
    #22;
    // ---- 1: reset values, then RESET -> INIT -> IDLE
    chk_state("rst", S_RESET);
    chk("rst.th_hi", th_hi, 3'd6);
    chk("rst.th_lo", th_lo, 3'd1);
    chk("rst.error_src", error_src, 5'b0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    step();
    chk_state("t1.e1", S_INIT);
    step();
    chk_state("t1.e2", S_IDLE);
    chk("t1.th_hi", th_hi, 3'd6);
    chk("t1.th_lo", th_lo, 3'd1);

    // ---- 2: IDLE -> INIT, hold init 3 cycles with new thresholds, exit to ACTIVE
    init = 1'b1; th_hi_in = 3'd5; th_lo_in = 3'd2;
    step();
    chk_state("t2.enter", S_INIT);
    chk("t2.th_hi_notyet", th_hi, 3'd6);
    step();
    step();
    step();
    chk_state("t2.hold", S_INIT);
    chk("t2.th_hi_loaded", th_hi, 3'd5);
    init = 1'b0; fifo_empty = 5'b11101;
    step();
    chk_state("t2.exit", S_ACTIVE);
    chk("t2.th_hi", th_hi, 3'd5);
    chk("t2.th_lo", th_lo, 3'd2);

    // ---- 3: ACTIVE, all FIFOs empty -> IDLE; counter reads qualified by idle
    fifo_empty = 5'b11111;
    th_hi_in = 3'd7; th_lo_in = 3'd0;
    step();
    chk_state("t3", S_IDLE);
    chk("t3.read_valid", idle, 1'b1);
    chk("t3.th_hi_hold", th_hi, 3'd5);

    // ---- 4: error and init together -> ERROR wins; ERROR sticky under init
    fifo_error = 5'b00100; init = 1'b1;
    step();
    chk_state("t4.err", S_ERROR);
    chk("t4.error_src", error_src, 5'b00100);
    fifo_error = 5'b00000;
    for (int i = 0; i < 4; i++) step();
    chk_state("t4.sticky", S_ERROR);
    chk("t4.error_src_hold", error_src, 5'b00100);
    chk("t4.th_hi_hold", th_hi, 3'd5);
    chk("t4.th_lo_hold", th_lo, 3'd2);

    // ---- 5: equal thresholds are a bad config -> ERROR with empty source mask
    #3 rst_l = 1'b0;
    #1;
    chk_state("t5.rst", S_RESET);
    chk("t5.rst_error_src", error_src, 5'b0);
    @(posedge clk); #1;
    rst_l = 1'b1; init = 1'b1; th_hi_in = 3'd3; th_lo_in = 3'd3;
    step();
    chk_state("t5.init", S_INIT);
    fifo_error = 5'b11111;
    step();
    chk_state("t5.err_dropped", S_INIT);
    fifo_error = 5'b00000; init = 1'b0;
    step();
    chk_state("t5.bad_cfg", S_ERROR);
    chk("t5.error_src", error_src, 5'b0);
    chk("t5.th_hi", th_hi, 3'd3);
    chk("t5.th_lo", th_lo, 3'd3);

    // ---- 6: ACTIVE, async reset mid-cycle restores defaults at once
    #3 rst_l = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b1; init = 1'b0; th_hi_in = 3'd5; th_lo_in = 3'd2; fifo_empty = 5'b11110;
    step();
    chk_state("t6.init", S_INIT);
    step();
    chk_state("t6.active", S_ACTIVE);
    chk("t6.th_hi_loaded", th_hi, 3'd5);
    #3 rst_l = 1'b0;
    #1;
    chk_state("t6.async", S_RESET);
    chk("t6.th_hi", th_hi, 3'd6);
    chk("t6.th_lo", th_lo, 3'd1);

    // ---- extra: IDLE -> ACTIVE on data, ACTIVE -> INIT, ACTIVE error mask capture
    @(posedge clk); #1;
    rst_l = 1'b1; fifo_empty = 5'b11111;
    step();
    step();
    chk_state("x.idle", S_IDLE);
    fifo_empty = 5'b01111;
    step();
    chk_state("x.idle2active", S_ACTIVE);
    init = 1'b1;
    step();
    chk_state("x.active2init", S_INIT);
    init = 1'b0;
    step();
    chk_state("x.back_active", S_ACTIVE);
    fifo_error = 5'b00011;
    step();
    chk_state("x.active_err", S_ERROR);
    chk("x.error_src", error_src, 5'b00011);
    fifo_error = 5'b00000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
